// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: single-precision layout and the exponent base
// used when packing a normalised 32-bit integer magnitude.
package fpu_pkg;

  localparam int EXP_W         = 8;
  localparam int MAN_W         = 23;
  localparam int BIAS          = 127;
  localparam int ITOF_EXP_BASE = BIAS + 31;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] val,
  output logic [5:0]  cnt
);

  // The highest set bit wins because the loop scans upward and later hits overwrite.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (val[i]) cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> IEEE single converter, round-to-nearest-even, valid/ready on both ends.
// Optional ITOF_UNSIGNED_EN adds in_unsigned to treat the operand as an unsigned 32-bit value.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
`ifdef ITOF_UNSIGNED_EN
  input  logic             in_unsigned,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  function automatic float_t round_pack(input logic sign, input logic nz,
                                        input logic [30:0] frac, input logic [5:0] lz);
    float_t         f;
    logic [MAN_W:0] sum;
    logic           rnd;
    rnd    = frac[7] & ((|frac[6:0]) | frac[8]);
    sum    = {1'b0, frac[30:8]} + (MAN_W+1)'(rnd);
    f.sign = sign;
    f.exp  = EXP_W'(ITOF_EXP_BASE) - EXP_W'(lz) + EXP_W'(sum[MAN_W]);
    f.man  = sum[MAN_W-1:0];
    if (!nz) f = '0;
    return f;
  endfunction

  logic vld_p0, vld_p1, vld_p2;
  logic adv_p0, adv_p1, adv_p2;
  logic ld_p0, ld_p1, ld_p2;

  assign adv_p2   = vld_p2 & out_ready;
  assign ld_p2    = !vld_p2 | adv_p2;
  assign adv_p1   = vld_p1 & ld_p2;
  assign ld_p1    = !vld_p1 | adv_p1;
  assign adv_p0   = vld_p0 & ld_p1;
  assign ld_p0    = !vld_p0 | adv_p0;
  assign in_ready = ld_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // S1: sign and magnitude; -2^31 wraps to 0x8000_0000, which is the correct magnitude.
  logic signed [31:0] op_s;
  logic               sign_s0;
  logic [31:0]        mag_s0;

  assign op_s = in_data;
`ifdef ITOF_UNSIGNED_EN
  assign sign_s0 = in_data[31] & !in_unsigned;
`else
  assign sign_s0 = in_data[31];
`endif
  assign mag_s0 = sign_s0 ? unsigned'(-op_s) : unsigned'(op_s);

  logic             sign_p0;
  logic [31:0]      mag_p0;
  logic [TAG_W-1:0] tag_p0;

  always_ff @(posedge clk) begin
    if (in_valid & ld_p0) begin
      sign_p0 <= sign_s0;
      mag_p0  <= mag_s0;
      tag_p0  <= in_tag;
    end
  end

  // S2: normalise so the leading one sits in bit 31; that bit doubles as the non-zero flag.
  logic [5:0]  lz_s1;
  logic [31:0] norm_s1;

  lzc32 u_lzc (
    .val (mag_p0),
    .cnt (lz_s1)
  );

  assign norm_s1 = mag_p0 << lz_s1;

  logic             sign_p1;
  logic             nz_p1;
  logic [30:0]      frac_p1;
  logic [5:0]       lz_p1;
  logic [TAG_W-1:0] tag_p1;

  always_ff @(posedge clk) begin
    if (vld_p0 & ld_p1) begin
      sign_p1 <= sign_p0;
      nz_p1   <= norm_s1[31];
      frac_p1 <= norm_s1[30:0];
      lz_p1   <= lz_s1;
      tag_p1  <= tag_p0;
    end
  end

  // S3: round, pack and hold the result until the consumer takes it.
  float_t           res_p2;
  logic [TAG_W-1:0] tag_p2;

  always_ff @(posedge clk) begin
    if (vld_p1 & ld_p2) begin
      res_p2 <= round_pack(sign_p1, nz_p1, frac_p1, lz_p1);
      tag_p2 <= tag_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = vld_p2 ? res_p2 : 32'd0;
  assign out_tag   = vld_p2 ? tag_p2 : '0;

endmodule

// File: tb/tb_itof_pipe.sv
// Directed bench for itof_pipe: reset, latency, rounding ties, backpressure, async reset, random stream.
// Build with ITOF_UNSIGNED_EN to also exercise the unsigned-operand port.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
`ifdef ITOF_UNSIGNED_EN
  logic        in_unsigned = 1'b0;
`endif

  itof_pipe #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef ITOF_UNSIGNED_EN
    .in_unsigned (in_unsigned),
`endif
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] vin [8];
  logic [31:0] vexp[8];
  int          vn;
  logic [31:0] bp_in [8];
  logic [31:0] bp_exp[8];
  logic [31:0] src_q[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_t[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  // Reference via the exact double image of the integer, rounded to 24 significant bits.
  function automatic logic [31:0] ref_itof(input logic [31:0] v, input bit uns);
    real         r;
    logic [63:0] b;
    int          e;
    logic [23:0] m;
    logic        up;
    if (uns) r = real'(longint'({32'd0, v}));
    else     r = real'(int'(v));
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return 32'd0;
    e  = int'(b[62:52]) - 1023 + 127;
    up = b[28] & ((|b[27:0]) | b[29]);
    m  = {1'b0, b[51:29]} + 24'(up);
    e  = e + int'(m[23]);
    return {b[63], e[7:0], m[22:0]};
  endfunction

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] e);
    vin[i]  = a;
    vexp[i] = e;
  endtask

  // One op per cycle, consumer always ready; result k must be visible exactly 3 cycles after it is offered.
  task automatic run_directed(input string name);
    for (int c = 0; c < vn + 4; c++) begin
      @(negedge clk);
      in_valid  = (c < vn);
      if (c < vn) begin
        in_data = vin[c];
        in_tag  = 4'(c);
      end
      out_ready = 1'b1;
      #1;
      if (c < vn) check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      if (c >= 3 && c - 3 < vn) begin
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"},  out_data, vexp[c-3]);
        check({name, "_tag"},   32'(out_tag), 32'(c - 3));
      end else begin
        check({name, "_idle"}, 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
  endtask

  int          oi, si, stall, cyc, k;
  logic [31:0] v, ed;
  logic [3:0]  et, tag_ctr;

  initial begin
    // Reset state, with an operand offered to show nothing leaks through.
    in_valid = 1'b1;
    in_data  = 32'd5;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_tag",   32'(out_tag), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    vn = 4;
    set_vec(0, 32'd1,         32'h3F80_0000);
    set_vec(1, 32'hFFFF_FFFF, 32'hBF80_0000);
    set_vec(2, 32'd0,         32'h0000_0000);
    set_vec(3, 32'h7FFF_FFFF, 32'h4F00_0000);
    run_directed("basic");

    vn = 4;
    set_vec(0, 32'd16777217,  32'h4B80_0000);
    set_vec(1, 32'd16777219,  32'h4B80_0002);
    set_vec(2, 32'd16777221,  32'h4B80_0002);
    set_vec(3, 32'h8000_0000, 32'hCF00_0000);
    run_directed("round");

    // Backpressure: 8 ops, consumer stalls 5 cycles after taking the first result.
    bp_in[0] = 32'd5;          bp_exp[0] = 32'h40A0_0000;
    bp_in[1] = -32'sd7;        bp_exp[1] = 32'hC0E0_0000;
    bp_in[2] = 32'd100;        bp_exp[2] = 32'h42C8_0000;
    bp_in[3] = 32'd16777217;   bp_exp[3] = 32'h4B80_0000;
    bp_in[4] = -32'sd16777219; bp_exp[4] = 32'hCB80_0002;
    bp_in[5] = 32'h4000_0000;  bp_exp[5] = 32'h4E80_0000;
    bp_in[6] = 32'd123456789;  bp_exp[6] = 32'h4CEB_79A3;
    bp_in[7] = -32'sd2;        bp_exp[7] = 32'hC000_0000;
    oi = 0; si = 0; stall = 0; cyc = 0;
    while (oi < 8 && cyc < 60) begin
      @(negedge clk);
      in_valid = (si < 8);
      if (si < 8) begin
        in_data = bp_in[si];
        in_tag  = 4'(si);
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data",  out_data, bp_exp[oi]);
        check("bp_hold_tag",   32'(out_tag), 32'(oi));
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        stall--;
      end
      if (out_valid && out_ready) begin
        check("bp_data", out_data, bp_exp[oi]);
        check("bp_tag",  32'(out_tag), 32'(oi));
        oi++;
        if (oi == 1) stall = 5;
      end
      if (in_valid && in_ready) si++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(oi), 32'd8);
    @(negedge clk);
    #1;
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Asynchronous reset with three ops in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'(10 + c);
      in_tag   = 4'(c);
      #1;
      check("rr_in_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("rr_pre_valid", 32'(out_valid), 32'd1);
    check("rr_pre_data",  out_data, 32'h4120_0000);
    #2;
    rst = 1'b1;
    #1;
    check("rr_async_valid", 32'(out_valid), 32'd0);
    check("rr_async_data",  out_data, 32'd0);
    check("rr_async_tag",   32'(out_tag), 32'd0);
    check("rr_async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("rr_no_stale", 32'(out_valid), 32'd0);
    end
    vn = 1;
    set_vec(0, 32'd3, 32'h4040_0000);
    run_directed("post_rst");

    // Random stream with bubbles on both sides; 10% are powers of two +/-1.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(9) == 0) begin
        k = int'($urandom_range(31));
        v = 32'd1 << k;
        case ($urandom_range(2))
          0:       v = v - 32'd1;
          1:       v = v + 32'd1;
          default: v = v;
        endcase
        if ($urandom_range(1) == 1) v = -v;
      end else begin
        v = $urandom;
      end
      src_q.push_back(v);
    end
    tag_ctr = 4'd0;
    cyc = 0;
    while ((src_q.size() > 0 || exp_d.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      in_valid = (src_q.size() > 0) && ($urandom_range(9) >= 2);
      if (src_q.size() > 0) in_data = src_q[0];
      in_tag    = tag_ctr;
      out_ready = ($urandom_range(9) >= 2);
      #1;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          check("rnd_extra", 32'(exp_d.size()), 32'd1);
        end else begin
          ed = exp_d.pop_front();
          et = exp_t.pop_front();
          check("rnd_data", out_data, ed);
          check("rnd_tag",  32'(out_tag), 32'(et));
        end
      end
      if (in_valid && in_ready) begin
        exp_d.push_back(ref_itof(in_data, 1'b0));
        exp_t.push_back(tag_ctr);
        tag_ctr = tag_ctr + 4'd1;
        void'(src_q.pop_front());
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_drain", 32'(exp_d.size() + src_q.size()), 32'd0);

`ifdef ITOF_UNSIGNED_EN
    in_unsigned = 1'b1;
    vn = 2;
    set_vec(0, 32'hFFFF_FFFF, 32'h4F80_0000);
    set_vec(1, 32'h8000_0000, 32'h4F00_0000);
    run_directed("uns");
    in_unsigned = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
